// File: rtl/bm_rng_pkg.sv
// Shared constants and types for the taus88 uniform random number bank.
package bm_rng_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARM,
        RUN
    } state_e;

    typedef struct packed {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
    } taus_t;

    localparam logic [31:0] MIN0 = 32'd2;
    localparam logic [31:0] MIN1 = 32'd8;
    localparam logic [31:0] MIN2 = 32'd16;

    localparam logic [31:0] SEED_B0 = 32'd2796307;
    localparam logic [31:0] SEED_B1 = 32'd2464179;
    localparam logic [31:0] SEED_B2 = 32'd1406639;

    // Per component: A = feedback shift, B = right shift, C = left shift
    localparam int T0_A = 13;
    localparam int T0_B = 19;
    localparam int T0_C = 12;
    localparam int T1_A = 2;
    localparam int T1_B = 25;
    localparam int T1_C = 4;
    localparam int T2_A = 3;
    localparam int T2_B = 11;
    localparam int T2_C = 17;

    localparam logic [31:0] T0_M = 32'hFFFF_FFFE;
    localparam logic [31:0] T1_M = 32'hFFFF_FFF8;
    localparam logic [31:0] T2_M = 32'hFFFF_FFF0;

    function automatic taus_t seed_default(input int k);
        taus_t s;
        s.s0 = (SEED_B0 + 32'(k)) | MIN0;
        s.s1 = (SEED_B1 + 32'(k)) | MIN1;
        s.s2 = (SEED_B2 + 32'(k)) | MIN2;
        return s;
    endfunction

endpackage

// File: rtl/taus88_step.sv
// One combinational taus88 step: next state and the raw 32-bit sample.
module taus88_step
    import bm_rng_pkg::*;
(
    input  taus_t       st_i,
    output taus_t       st_o,
    output logic [31:0] smp_o
);

    always_comb begin
        st_o.s0 = ((st_i.s0 & T0_M) << T0_C)
                ^ (((st_i.s0 << T0_A) ^ st_i.s0) >> T0_B);
        st_o.s1 = ((st_i.s1 & T1_M) << T1_C)
                ^ (((st_i.s1 << T1_A) ^ st_i.s1) >> T1_B);
        st_o.s2 = ((st_i.s2 & T2_M) << T2_C)
                ^ (((st_i.s2 << T2_A) ^ st_i.s2) >> T2_B);
    end

    assign smp_o = st_o.s0 ^ st_o.s1 ^ st_o.s2;

endmodule

// File: rtl/taus_urng_bank.sv
// Bank of lock-stepped taus88 generators with warm-up and a valid/ready output.
module taus_urng_bank
    import bm_rng_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 16,
    parameter int WARMUP = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_in0,
    input  logic                    scan_en,
    input  logic                    test_mode,
    output logic                    scan_out0,
    input  logic                    gen_en,
    input  logic                    seed_wr,
    input  logic [2:0]              seed_ch,
    input  logic [1:0]              seed_idx,
    input  logic [31:0]             seed_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [NUM_CH*OUT_W-1:0] out_data,
    output logic                    busy
);

    localparam int CW = 8;

    state_e                    state_q, state_d, act;
    taus_t                     seed_q [NUM_CH];
    taus_t                     nxt    [NUM_CH];
    logic [NUM_CH-1:0][31:0]   smp;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      pend_q, pend_d;
    logic                      valid_q, valid_d;
    logic [NUM_CH*OUT_W-1:0]   data_q, data_d;
    logic                      step, seed_ok;
    logic                      dft_unused, smp_unused;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        taus88_step u_step (
            .st_i  (seed_q[k]),
            .st_o  (nxt[k]),
            .smp_o (smp[k])
        );
    end

    assign seed_ok = seed_wr && (int'(seed_ch) < NUM_CH)
                             && (seed_idx != 2'd3);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        valid_d = valid_q && !out_ready;
        data_d  = data_q;
        step    = 1'b0;
        act     = state_q;
        // Leaving IDLE does the first cycle of the target state's work
        if (state_q == IDLE && gen_en) begin
            act = (pend_q && cnt_q != '0) ? WARM : RUN;
        end
        unique case (act)
            IDLE: ;
            WARM: begin
                if (!gen_en) begin
                    state_d = IDLE;
                end else begin
                    step    = 1'b1;
                    cnt_d   = cnt_q - CW'(1);
                    state_d = WARM;
                    if (cnt_q == CW'(1)) begin
                        state_d = RUN;
                        pend_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (!gen_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                    if (!valid_q || out_ready) begin
                        step    = 1'b1;
                        valid_d = 1'b1;
                        for (int k = 0; k < NUM_CH; k++) begin
                            data_d[k*OUT_W +: OUT_W] = smp[k][31 -: OUT_W];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (seed_ok) begin
            step    = 1'b0;
            valid_d = 1'b0;
            data_d  = data_q;
            state_d = IDLE;
            pend_d  = 1'b1;
            cnt_d   = CW'(WARMUP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CW'(WARMUP);
            pend_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                seed_q[k] <= seed_default(k);
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (seed_ok && int'(seed_ch) == k) begin
                    unique case (seed_idx)
                        2'd0:    seed_q[k].s0 <= seed_data | MIN0;
                        2'd1:    seed_q[k].s1 <= seed_data | MIN1;
                        2'd2:    seed_q[k].s2 <= seed_data | MIN2;
                        default: ;
                    endcase
                end else if (step) begin
                    seed_q[k] <= nxt[k];
                end
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign busy       = (state_q == WARM);
    assign scan_out0  = 1'b0;
    assign dft_unused = scan_in0 ^ scan_en ^ test_mode;
    assign smp_unused = ^smp;

endmodule
